// File: rtl/dmem_wait_responder_pkg.sv
// dmem_wait_responder shared types and constants.
// Holds the FSM state enum, the error word and the index-width helper.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } dmem_state_t;

  localparam logic [31:0] DMEM_ERR_WORD = 32'hDEADBEEF;

  function automatic int dmem_idx_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/dmem_wait_responder_if.sv
// Data-bus stall-protocol bundle between the core and the memory.
// The err wire exists only when DMEM_WAIT_ERR_EN is defined.
interface dmem_wait_responder_if;

  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] data_w;
  logic [31:0] data_r;
  logic        bus_wait;
`ifdef DMEM_WAIT_ERR_EN
  logic        err;
`endif

  modport master (
    output req,
    output we,
    output addr,
    output data_w,
    input  data_r,
    input  bus_wait
`ifdef DMEM_WAIT_ERR_EN
    ,
    input  err
`endif
  );

  modport slave (
    input  req,
    input  we,
    input  addr,
    input  data_w,
    output data_r,
    output bus_wait
`ifdef DMEM_WAIT_ERR_EN
    ,
    output err
`endif
  );

endinterface

// File: rtl/dmem_wait_responder_ctr.sv
// Wait-state sequencer: IDLE -> BUSY (cnt) -> DONE -> IDLE.
// to_done marks the edge that enters DONE (load capture point).
module dmem_wait_ctr
  import dmem_pkg::*;
#(
  parameter int LATENCY = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic req,
  output logic done,
  output logic busy,
  output logic to_done
);

  localparam logic [3:0] LAST = 4'(LATENCY - 1);

  dmem_state_t r_state;
  dmem_state_t w_nxt_state;
  logic [3:0]  r_cnt;
  logic [3:0]  w_nxt_cnt;

  // Next state and wait count; a dropped req in BUSY aborts.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    unique case (r_state)
      IDLE: begin
        if (req) begin
          if (LATENCY == 1) begin
            w_nxt_state = DONE;
          end else begin
            w_nxt_state = BUSY;
            w_nxt_cnt   = 4'd1;
          end
        end
      end
      BUSY: begin
        if (!req) begin
          w_nxt_state = IDLE;
          w_nxt_cnt   = 4'd0;
        end else if (r_cnt == LAST) begin
          w_nxt_state = DONE;
        end else begin
          w_nxt_cnt = r_cnt + 4'd1;
        end
      end
      DONE: begin
        w_nxt_state = IDLE;
        w_nxt_cnt   = 4'd0;
      end
      default: begin
        w_nxt_state = IDLE;
        w_nxt_cnt   = 4'd0;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_nxt_state;
      r_cnt   <= w_nxt_cnt;
    end
  end

  assign done    = (r_state == DONE);
  assign busy    = (r_state == BUSY);
  assign to_done = (w_nxt_state == DONE) && (r_state != DONE);

endmodule

// File: rtl/dmem_wait_responder.sv
// Multi-cycle data memory on the bus_wait stall protocol.
// Optional DMEM_WAIT_ERR_EN: out-of-range flag, dropped stores, DEADBEEF.
module dmem_wait_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input logic                  clk,
  input logic                  reset,
  dmem_wait_responder_if.slave bus
);

  localparam int IW = dmem_idx_w(DEPTH);

  logic [31:0]   r_mem [DEPTH];
  logic [31:0]   r_data_r;
  logic [IW-1:0] w_idx;
  logic          w_oor;
  logic          w_done;
  logic          w_busy;
  logic          w_to_done;
  logic          w_unused;

  dmem_wait_ctr #(
    .LATENCY(LATENCY)
  ) u_ctr (
    .clk    (clk),
    .reset  (reset),
    .req    (bus.req),
    .done   (w_done),
    .busy   (w_busy),
    .to_done(w_to_done)
  );

  assign w_idx = bus.addr[IW+1:2];

`ifdef DMEM_WAIT_ERR_EN
  logic r_err;

  assign w_oor    = |bus.addr[31:IW+2];
  assign w_unused = ^{bus.addr[1:0], w_busy};
  assign bus.err  = r_err;

  // err is a one-cycle pulse coinciding with DONE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_to_done & w_oor;
    end
  end
`else
  assign w_oor    = 1'b0;
  assign w_unused = ^{bus.addr[31:IW+2], bus.addr[1:0], w_busy};
`endif

  // Stall from the request cycle itself; never while in reset.
  assign bus.bus_wait = reset & bus.req & ~w_done;

  // Load data is captured on the edge that enters DONE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data_r <= 32'd0;
    end else if (w_to_done && !bus.we) begin
      r_data_r <= w_oor ? DMEM_ERR_WORD : r_mem[w_idx];
    end
  end

  assign bus.data_r = r_data_r;

  // Stores commit on the edge leaving DONE; reset clears DONE first.
  always_ff @(posedge clk) begin
    if (w_done && bus.we && !w_oor) begin
      r_mem[w_idx] <= bus.data_w;
    end
  end

endmodule
